// File: rtl/io_ctrl_pkg.sv
// Shared IO-controller types: debouncer state encoding and a level helper.
package io_ctrl_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } debounce_state_t;

    // Debounced level presented while in a given state.
    function automatic logic state_level(input debounce_state_t s);
        return (s == STABLE_HI) || (s == PEND_LO);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV enabled clocks.
module tick_prescaler #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    if (DIV < 1) begin : g_bad_div
        $error("tick_prescaler: DIV must be >= 1");
    end

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes a raw pin and only passes a level change once it has been
// seen on STABLE_CNT consecutive sample ticks.
module input_debouncer
    import io_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int STABLE_CNT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic data_in,
    output logic data_out,
    output logic changed,
    output logic sample_tick
);

    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam logic [SW-1:0] SC_LAST = SW'(STABLE_CNT - 1);

    if (TICK_DIV < 1 || STABLE_CNT < 1) begin : g_bad_params
        $error("input_debouncer: TICK_DIV and STABLE_CNT must be >= 1");
    end

    logic            sync0, sync1, data_s;
    debounce_state_t state, next_state;
    logic [SW-1:0]   sc, next_sc;
    logic            next_out, next_changed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= data_in;
            sync1 <= sync0;
        end
    end

    assign data_s = sync1;

    tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (sample_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= STABLE_LO;
            sc       <= '0;
            data_out <= 1'b0;
            changed  <= 1'b0;
        end else begin
            state    <= next_state;
            sc       <= next_sc;
            data_out <= next_out;
            changed  <= next_changed;
        end
    end

    always_comb begin
        next_state = state;
        next_sc    = sc;
        if (sample_tick) begin
            unique case (state)
                STABLE_LO: if (data_s) begin
                    if (STABLE_CNT == 1) begin
                        next_state = STABLE_HI;
                    end else begin
                        next_state = PEND_HI;
                        next_sc    = SW'(1);
                    end
                end
                PEND_HI: if (!data_s) begin
                    next_state = STABLE_LO;
                    next_sc    = '0;
                end else if (sc == SC_LAST) begin
                    next_state = STABLE_HI;
                    next_sc    = '0;
                end else begin
                    next_sc = sc + SW'(1);
                end
                STABLE_HI: if (!data_s) begin
                    if (STABLE_CNT == 1) begin
                        next_state = STABLE_LO;
                    end else begin
                        next_state = PEND_LO;
                        next_sc    = SW'(1);
                    end
                end
                PEND_LO: if (data_s) begin
                    next_state = STABLE_HI;
                    next_sc    = '0;
                end else if (sc == SC_LAST) begin
                    next_state = STABLE_LO;
                    next_sc    = '0;
                end else begin
                    next_sc = sc + SW'(1);
                end
            endcase
        end
    end

    // data_out is registered from the next state so it flips on the same
    // edge the FSM enters a stable state; changed marks that edge.
    always_comb begin
        next_out     = state_level(next_state);
        next_changed = (next_out != data_out);
    end

endmodule
